// File: rtl/qam64_bit_packer.sv
// Packs an MSB-first byte stream into 6-bit QAM-64 symbol indices, zero-padding
// the final symbol of each frame and reporting the per-frame symbol count.
module qam64_bit_packer #(
    parameter int IN_W  = 8,
    parameter int SYM_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [SYM_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_syms,
    output logic             frame_done
);

    localparam int ACC_W = IN_W + SYM_W;
    localparam int CW    = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] frame_syms_q, frame_syms_d;
    logic             frame_done_q, frame_done_d;

    logic             emit_s;
    logic             accept_s;
    logic [ACC_W-1:0] acc_sh_s;
    logic [CW-1:0]    cnt_sh_s;
    logic [ACC_W-1:0] in_word_s;

    // Handshake-side outputs are pure decodes of the storage registers.
    always_comb begin
        in_ready   = !flush_q && (cnt_q <= CW'(ACC_W - IN_W));
        out_valid  = (cnt_q >= CW'(SYM_W)) || (flush_q && (cnt_q != {CW{1'b0}}));
        out_last   = flush_q && (cnt_q <= CW'(SYM_W)) && (cnt_q != {CW{1'b0}});
        out_data   = acc_q[ACC_W-1 -: SYM_W];
        frame_syms = frame_syms_q;
        frame_done = frame_done_q;
    end

    // Next state: emit shift first, then the accepted word lands just below the surviving bits.
    always_comb begin
        emit_s    = out_valid && out_ready;
        accept_s  = in_valid && in_ready;
        acc_sh_s  = acc_q;
        cnt_sh_s  = cnt_q;
        if (emit_s) begin
            acc_sh_s = acc_q << SYM_W;
            if (cnt_q >= CW'(SYM_W)) begin
                cnt_sh_s = cnt_q - CW'(SYM_W);
            end else begin
                cnt_sh_s = {CW{1'b0}};
            end
        end else begin
            acc_sh_s = acc_q;
            cnt_sh_s = cnt_q;
        end
        in_word_s = {in_data, {SYM_W{1'b0}}} >> cnt_sh_s;

        acc_d        = acc_sh_s;
        cnt_d        = cnt_sh_s;
        flush_d      = flush_q;
        sym_cnt_d    = sym_cnt_q;
        frame_syms_d = frame_syms_q;
        frame_done_d = 1'b0;

        if (accept_s) begin
            acc_d = acc_sh_s | in_word_s;
            cnt_d = cnt_sh_s + CW'(IN_W);
        end else begin
            acc_d = acc_sh_s;
            cnt_d = cnt_sh_s;
        end

        if (emit_s && out_last) begin
            flush_d      = 1'b0;
            cnt_d        = {CW{1'b0}};
            frame_syms_d = sym_cnt_q + CNT_W'(1);
            sym_cnt_d    = {CNT_W{1'b0}};
            frame_done_d = 1'b1;
        end else if (emit_s) begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
            if (accept_s && in_last) begin
                flush_d = 1'b1;
            end else begin
                flush_d = flush_q;
            end
        end else begin
            if (accept_s && in_last) begin
                flush_d = 1'b1;
            end else begin
                flush_d = flush_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q        <= {ACC_W{1'b0}};
            cnt_q        <= {CW{1'b0}};
            flush_q      <= 1'b0;
            sym_cnt_q    <= {CNT_W{1'b0}};
            frame_syms_q <= {CNT_W{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            sym_cnt_q    <= sym_cnt_d;
            frame_syms_q <= frame_syms_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_qam64_bit_packer.sv
// Self-checking bench for qam64_bit_packer: directed frame table, random streams
// with backpressure and a mid-frame reset, against a bit-queue reference model.
module tb_qam64_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [5:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [15:0] frame_syms;
    logic        frame_done;

    always #5 clk = ~clk;

    qam64_bit_packer #(.IN_W(8), .SYM_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .frame_syms(frame_syms), .frame_done(frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffered bits as a queue, oldest bit first.
    bit          mq[$];
    bit          m_flush = 1'b0;
    logic [15:0] m_symcnt = 16'd0;
    logic [15:0] m_fsyms = 16'd0;
    bit          m_fdone = 1'b0;

    logic [6:0]  got[$];
    bit          prev_stall = 1'b0;
    logic [5:0]  prev_data;
    logic        prev_last;

    typedef struct {
        logic [23:0] words;
        int          nw;
        logic [23:0] syms;
        int          ns;
    } vec_t;
    vec_t vt[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_valid();
        return (mq.size() >= 6) || (m_flush && (mq.size() != 0));
    endfunction

    function automatic bit m_lastf();
        return m_flush && (mq.size() <= 6) && (mq.size() != 0);
    endfunction

    function automatic bit m_ready();
        return !m_flush && (mq.size() <= 6);
    endfunction

    function automatic logic [5:0] m_data();
        logic [5:0] d = 6'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < mq.size()) d[5-i] = mq[i];
        end
        return d;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_flush  = 1'b0;
        m_symcnt = 16'd0;
        m_fsyms  = 16'd0;
        m_fdone  = 1'b0;
    endfunction

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input bit iv, input logic [7:0] id, input bit il, input bit ordy, output bit acc);
        bit em;
        bit lst;
        int k;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        in_last   = il;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        chk("out_valid", 32'(out_valid), 32'(m_valid()));
        if (m_valid()) chk("out_data", 32'(out_data), 32'(m_data()));
        chk("out_last", 32'(out_last), 32'(m_lastf()));
        chk("frame_syms", 32'(frame_syms), 32'(m_fsyms));
        chk("frame_done", 32'(frame_done), 32'(m_fdone));
        if (prev_stall) begin
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        prev_stall = out_valid && !ordy;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && ordy) got.push_back({out_last, out_data});

        em  = m_valid() && ordy;
        lst = m_lastf();
        acc = iv && m_ready();
        m_fdone = em && lst;
        if (em) begin
            k = (mq.size() < 6) ? mq.size() : 6;
            repeat (k) void'(mq.pop_front());
            if (lst) begin
                m_fsyms  = m_symcnt + 16'd1;
                m_symcnt = 16'd0;
                m_flush  = 1'b0;
            end else begin
                m_symcnt = m_symcnt + 16'd1;
            end
        end
        if (acc) begin
            for (int i = 7; i >= 0; i--) mq.push_back(id[i]);
            if (il) m_flush = 1'b1;
        end
    endtask

    // Feed a word list; with last set, run until the final symbol handshakes.
    task automatic send_words(input logic [7:0] w[$], input bit last, input bit rnd, input int budget);
        int idx = 0;
        int cyc = 0;
        bit a;
        bit done = 1'b0;
        got.delete();
        while (!done && cyc < budget) begin
            if (idx < w.size())
                cycle(1'b1, w[idx], last && (idx == w.size() - 1), rnd ? 1'($urandom_range(0, 1)) : 1'b1, a);
            else
                cycle(1'b0, 8'($urandom), 1'($urandom), rnd ? 1'($urandom_range(0, 1)) : 1'b1, a);
            if (a) idx++;
            cyc++;
            if (last) done = (got.size() > 0) && got[got.size()-1][6];
            else      done = (idx == w.size());
        end
        if (!done) chk("timeout", 32'(cyc), 32'(budget + 1));
    endtask

    // Expected symbols straight from the MSB-first bit string with zero padding.
    function automatic void ref_syms(input logic [7:0] w[$], output logic [6:0] r[$]);
        bit bits[$];
        logic [5:0] s;
        int nsym;
        r.delete();
        foreach (w[i]) for (int b = 7; b >= 0; b--) bits.push_back(w[i][b]);
        nsym = (bits.size() + 5) / 6;
        for (int j = 0; j < nsym; j++) begin
            s = 6'd0;
            for (int b = 0; b < 6; b++) if (j*6 + b < bits.size()) s[5-b] = bits[j*6 + b];
            r.push_back({(j == nsym - 1) ? 1'b1 : 1'b0, s});
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        prev_stall = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_frame_syms", 32'(frame_syms), 32'd0);
    endtask

    task automatic check_frame_end(input int ns);
        bit a;
        @(posedge clk);
        #1;
        chk("end_frame_done", 32'(frame_done), 32'd1);
        chk("end_frame_syms", 32'(frame_syms), 32'(ns));
        cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
    endtask

    initial begin
        logic [7:0] w[$];
        logic [6:0] r[$];

        vt[0] = '{24'hFC0FC3, 3, {6'h3F, 6'h00, 6'h3F, 6'h03}, 4};
        vt[1] = '{24'hA50000, 1, {6'h29, 6'h10, 12'h000}, 2};
        vt[2] = '{24'hFFFF00, 2, {6'h3F, 6'h3F, 6'h3C, 6'h00}, 3};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        do_reset();

        // Directed frames from the table.
        for (int v = 0; v < 3; v++) begin
            w.delete();
            for (int i = 0; i < vt[v].nw; i++) w.push_back(vt[v].words[23 - 8*i -: 8]);
            send_words(w, 1'b1, 1'b0, 200);
            chk("tbl_nsyms", 32'(got.size()), 32'(vt[v].ns));
            for (int i = 0; i < vt[v].ns && i < got.size(); i++)
                chk("tbl_sym", 32'(got[i]),
                    32'({(i == vt[v].ns - 1) ? 1'b1 : 1'b0, vt[v].syms[23 - 6*i -: 6]}));
            check_frame_end(vt[v].ns);
        end

        // 300-word streams, first with out_ready held high, then with random backpressure.
        for (int pass = 0; pass < 2; pass++) begin
            w.delete();
            for (int i = 0; i < 300; i++) w.push_back(8'($urandom));
            ref_syms(w, r);
            send_words(w, 1'b1, pass == 1, 5000);
            chk("stream_nsyms", 32'(got.size()), 32'd400);
            for (int i = 0; i < r.size() && i < got.size(); i++) chk("stream_sym", 32'(got[i]), 32'(r[i]));
            check_frame_end(400);
        end

        // Reset in the middle of a frame, then a fresh short frame.
        w.delete();
        for (int i = 0; i < 5; i++) w.push_back(8'($urandom));
        send_words(w, 1'b0, 1'b1, 200);
        do_reset();
        w.delete();
        w.push_back(8'hA5);
        send_words(w, 1'b1, 1'b0, 200);
        chk("post_rst_nsyms", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("post_rst_sym0", 32'(got[0]), 32'h29);
            chk("post_rst_sym1", 32'(got[1]), 32'h50);
        end
        check_frame_end(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
